// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multicycle RV32I control FSM. Drives the datapath strobes and
//               muxes for FETCH/DECODE plus load, store, R-type, I-type ALU,
//               BEQ/BNE and JAL. Flags illegal opcodes and counts retired
//               instructions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: CTRL_MEM_WAIT_EN
//   Defined  : mem_ready port exists. FETCH/MEMREAD/MEMWRITE wait for
//              mem_ready. Waits longer than MEM_TIMEOUT cycles go to ILLEGAL.
//   Undefined: no mem_ready port. Each memory state lasts one cycle.
// ----------------------------------------------------------------------------
// Ports
//   clk           in   clock, all state updates on posedge
//   reset         in   synchronous, active-low
//   opcode        in   IR[6:0]
//   funct3        in   IR[14:12]
//   func7_bit5    in   IR[30]
//   zero          in   ALU zero flag
//   mem_ready     in   memory access done (CTRL_MEM_WAIT_EN only)
//   pcwrite       out  PC load enable
//   adrsource     out  0=PC, 1=ALUOut as memory address
//   memwrite      out  memory write strobe
//   irwrite       out  IR/OldPC load enable
//   regwrite      out  regfile write enable
//   imm_source    out  00=I 01=S 10=B 11=J
//   alu_source_a  out  00=PC 01=OldPC 10=RD1
//   alu_source_b  out  00=RD2 01=ImmExt 10=const 4
//   alu_control   out  ADD=000 SUB=001 AND=010 OR=011 SLT=101
//   resultsource  out  00=ALU result 01=mem data 10=ALUOut reg
//   illegal_instr out  sticky illegal-instruction flag
//   retired_count out  instructions completed since reset (wraps)
// ============================================================================
module mc_control_fsm #(
  parameter int ALU_CTRL_W  = 3,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  func7_bit5,
  input  logic                  zero,
`ifdef CTRL_MEM_WAIT_EN
  input  logic                  mem_ready,
`endif
  output logic                  pcwrite,
  output logic                  adrsource,
  output logic                  memwrite,
  output logic                  irwrite,
  output logic                  regwrite,
  output logic [1:0]            imm_source,
  output logic [1:0]            alu_source_a,
  output logic [1:0]            alu_source_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            resultsource,
  output logic                  illegal_instr,
  output logic [CNT_W-1:0]      retired_count
);

  // Opcodes
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  // ALU operation codes
  localparam logic [ALU_CTRL_W-1:0] c_ALU_ADD = ALU_CTRL_W'(3'b000);
  localparam logic [ALU_CTRL_W-1:0] c_ALU_SUB = ALU_CTRL_W'(3'b001);
  localparam logic [ALU_CTRL_W-1:0] c_ALU_AND = ALU_CTRL_W'(3'b010);
  localparam logic [ALU_CTRL_W-1:0] c_ALU_OR  = ALU_CTRL_W'(3'b011);
  localparam logic [ALU_CTRL_W-1:0] c_ALU_SLT = ALU_CTRL_W'(3'b101);

  // Mux select encodings
  localparam logic [1:0] c_IMM_I   = 2'b00;
  localparam logic [1:0] c_IMM_S   = 2'b01;
  localparam logic [1:0] c_IMM_B   = 2'b10;
  localparam logic [1:0] c_IMM_J   = 2'b11;
  localparam logic [1:0] c_A_PC    = 2'b00;
  localparam logic [1:0] c_A_OLDPC = 2'b01;
  localparam logic [1:0] c_A_RD1   = 2'b10;
  localparam logic [1:0] c_B_RD2   = 2'b00;
  localparam logic [1:0] c_B_IMM   = 2'b01;
  localparam logic [1:0] c_B_FOUR  = 2'b10;
  localparam logic [1:0] c_RES_ALU = 2'b00;
  localparam logic [1:0] c_RES_MEM = 2'b01;
  localparam logic [1:0] c_RES_OUT = 2'b10;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_retire;
  logic               w_mem_ready;
  logic               w_timeout;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_retired_count;

`ifdef CTRL_MEM_WAIT_EN
  localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                w_wait_state;

  assign w_mem_ready  = mem_ready;
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                        (r_state == S_MEMWRITE);
  // The edge that ends the MEM_TIMEOUT-th waiting cycle is the one that
  // abandons the access.
  assign w_timeout    = (r_wait_cnt == c_WAIT_W'(MEM_TIMEOUT - 1));

  // Counts waiting cycles; restarts from zero whenever the state changes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (w_next != r_state) begin
      r_wait_cnt <= '0;
    end else if (w_wait_state && !mem_ready && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  assign w_mem_ready = 1'b1;
  assign w_timeout   = 1'b0;

  // MEM_TIMEOUT has no effect without the wait handshake.
  if (MEM_TIMEOUT >= 1) begin : g_no_mem_wait
  end
`endif

  // State register and status
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_RESET;
      r_illegal       <= 1'b0;
      r_retired_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_ILLEGAL) begin
        r_illegal <= 1'b1;
      end
      if (w_retire) begin
        r_retired_count <= r_retired_count + 1'b1;
      end
    end
  end

  assign illegal_instr = r_illegal;
  assign retired_count = r_retired_count;

  // Next-state and output decode
  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    pcwrite      = 1'b0;
    adrsource    = 1'b0;
    memwrite     = 1'b0;
    irwrite      = 1'b0;
    regwrite     = 1'b0;
    imm_source   = c_IMM_I;
    alu_source_a = c_A_PC;
    alu_source_b = c_B_RD2;
    alu_control  = c_ALU_ADD;
    resultsource = c_RES_ALU;

    case (r_state)
      S_RESET: begin
        w_next = S_FETCH;
      end

      S_FETCH: begin
        alu_source_a = c_A_PC;
        alu_source_b = c_B_FOUR;
        irwrite      = w_mem_ready;
        pcwrite      = w_mem_ready;
        if (w_mem_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_ILLEGAL;
        end
      end

      S_DECODE: begin
        // Precompute the branch/jump target while the opcode is decoded.
        alu_source_a = c_A_OLDPC;
        alu_source_b = c_B_IMM;
        imm_source   = (opcode == c_OP_JAL) ? c_IMM_J : c_IMM_B;
        case (opcode)
          c_OP_LOAD,
          c_OP_STORE:  w_next = S_MEMADR;
          c_OP_RTYPE:  w_next = S_EXECR;
          c_OP_ITYPE:  w_next = S_EXECI;
          c_OP_BRANCH: w_next = S_BRANCH;
          c_OP_JAL:    w_next = S_JAL;
          default:     w_next = S_ILLEGAL;
        endcase
      end

      S_MEMADR: begin
        alu_source_a = c_A_RD1;
        alu_source_b = c_B_IMM;
        if (opcode == c_OP_STORE) begin
          imm_source = c_IMM_S;
          w_next     = S_MEMWRITE;
        end else begin
          imm_source = c_IMM_I;
          w_next     = S_MEMREAD;
        end
      end

      S_MEMREAD: begin
        adrsource    = 1'b1;
        resultsource = c_RES_OUT;
        if (w_mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_timeout) begin
          w_next = S_ILLEGAL;
        end
      end

      S_MEMWB: begin
        resultsource = c_RES_MEM;
        regwrite     = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end

      S_MEMWRITE: begin
        adrsource    = 1'b1;
        resultsource = c_RES_OUT;
        memwrite     = w_mem_ready;
        if (w_mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_timeout) begin
          w_next = S_ILLEGAL;
        end
      end

      S_EXECR: begin
        alu_source_a = c_A_RD1;
        alu_source_b = c_B_RD2;
        w_next       = S_ALUWB;
        case (funct3)
          3'b000:  alu_control = func7_bit5 ? c_ALU_SUB : c_ALU_ADD;
          3'b111:  alu_control = c_ALU_AND;
          3'b110:  alu_control = c_ALU_OR;
          3'b010:  alu_control = c_ALU_SLT;
          default: w_next      = S_ILLEGAL;
        endcase
      end

      S_EXECI: begin
        // IR[30] is immediate data here, so 000 is always ADD.
        alu_source_a = c_A_RD1;
        alu_source_b = c_B_IMM;
        imm_source   = c_IMM_I;
        w_next       = S_ALUWB;
        case (funct3)
          3'b000:  alu_control = c_ALU_ADD;
          3'b111:  alu_control = c_ALU_AND;
          3'b110:  alu_control = c_ALU_OR;
          3'b010:  alu_control = c_ALU_SLT;
          default: w_next      = S_ILLEGAL;
        endcase
      end

      S_ALUWB: begin
        resultsource = c_RES_OUT;
        regwrite     = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end

      S_BRANCH: begin
        // ALUOut holds the target computed in DECODE; the ALU compares.
        alu_source_a = c_A_RD1;
        alu_source_b = c_B_RD2;
        alu_control  = c_ALU_SUB;
        resultsource = c_RES_OUT;
        case (funct3)
          3'b000: begin
            pcwrite  = zero;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          3'b001: begin
            pcwrite  = ~zero;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          default: w_next = S_ILLEGAL;
        endcase
      end

      S_JAL: begin
        // PC <- target from ALUOut while the ALU forms OldPC+4 for rd.
        alu_source_a = c_A_OLDPC;
        alu_source_b = c_B_FOUR;
        resultsource = c_RES_OUT;
        pcwrite      = 1'b1;
        w_next       = S_ALUWB;
      end

      S_ILLEGAL: begin
        w_next = S_ILLEGAL;
      end

      default: begin
        w_next = S_RESET;
      end
    endcase

    // An instruction interrupted by reset must not commit anything.
    if (!reset) begin
      pcwrite  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      w_retire = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Directed self-checking bench for mc_control_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        func7_bit5;
  logic        zero;
`ifdef CTRL_MEM_WAIT_EN
  logic        mem_ready;
`endif
  logic        pcwrite, adrsource, memwrite, irwrite, regwrite;
  logic [1:0]  imm_source, alu_source_a, alu_source_b, resultsource;
  logic [2:0]  alu_control;
  logic        illegal_instr;
  logic [31:0] retired_count;
  logic [15:0] ctl;

  int n_assert = 0;
  int n_fail   = 0;

  mc_control_fsm #(
    .ALU_CTRL_W (3),
    .CNT_W      (32),
    .MEM_TIMEOUT(15)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .func7_bit5   (func7_bit5),
    .zero         (zero),
`ifdef CTRL_MEM_WAIT_EN
    .mem_ready    (mem_ready),
`endif
    .pcwrite      (pcwrite),
    .adrsource    (adrsource),
    .memwrite     (memwrite),
    .irwrite      (irwrite),
    .regwrite     (regwrite),
    .imm_source   (imm_source),
    .alu_source_a (alu_source_a),
    .alu_source_b (alu_source_b),
    .alu_control  (alu_control),
    .resultsource (resultsource),
    .illegal_instr(illegal_instr),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctl = {pcwrite, adrsource, memwrite, irwrite, regwrite, imm_source,
                alu_source_a, alu_source_b, alu_control, resultsource};

  // pc adr mw ir rw | imm | a | b | alu | res
  function automatic logic [15:0] mk(input logic pc, input logic adr,
                                     input logic mw, input logic ir,
                                     input logic rw, input logic [1:0] imm,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] alu,
                                     input logic [1:0] res);
    return {pc, adr, mw, ir, rw, imm, a, b, alu, res};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e_fetch, e_dec_b, e_alu_wb;
    e_fetch  = mk(1,0,0,1,0,2'b00,2'b00,2'b10,3'b000,2'b00);
    e_dec_b  = mk(0,0,0,0,0,2'b10,2'b01,2'b01,3'b000,2'b00);
    e_alu_wb = mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b10);

    reset = 1'b0; opcode = '0; funct3 = '0; func7_bit5 = 1'b0; zero = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    repeat (2) step;
    check_eq("rst_ctl", 32'(ctl), 32'h0);
    check_eq("rst_illegal", 32'(illegal_instr), 32'h0);
    check_eq("rst_count", retired_count, 32'h0);

    // lw
    reset = 1'b1; opcode = 7'b0000011; funct3 = 3'b010;
    step; check_eq("lw_fetch", 32'(ctl), 32'(e_fetch));
    step; check_eq("lw_decode", 32'(ctl), 32'(e_dec_b));
    step; check_eq("lw_memadr", 32'(ctl), 32'(mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00)));
    step; check_eq("lw_memread", 32'(ctl), 32'(mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b10)));
    step; check_eq("lw_memwb", 32'(ctl), 32'(mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b01)));
    step; check_eq("lw_back_fetch", 32'(ctl), 32'(e_fetch));
    check_eq("lw_count", retired_count, 32'd1);

    // sub
    opcode = 7'b0110011; funct3 = 3'b000; func7_bit5 = 1'b1;
    step; check_eq("sub_decode", 32'(ctl), 32'(e_dec_b));
    step; check_eq("sub_execr", 32'(ctl), 32'(mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00)));
    step; check_eq("sub_aluwb", 32'(ctl), 32'(e_alu_wb));
    step; check_eq("sub_count", retired_count, 32'd2);

    // sw
    opcode = 7'b0100011; funct3 = 3'b010; func7_bit5 = 1'b0;
    step;
    step; check_eq("sw_memadr", 32'(ctl), 32'(mk(0,0,0,0,0,2'b01,2'b10,2'b01,3'b000,2'b00)));
    step; check_eq("sw_memwrite", 32'(ctl), 32'(mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b10)));
    step; check_eq("sw_count", retired_count, 32'd3);

    // ori
    opcode = 7'b0010011; funct3 = 3'b110; func7_bit5 = 1'b1;
    step;
    step; check_eq("ori_execi", 32'(ctl), 32'(mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b011,2'b00)));
    step; check_eq("ori_aluwb", 32'(ctl), 32'(e_alu_wb));
    step; check_eq("ori_count", retired_count, 32'd4);

    // beq taken
    opcode = 7'b1100011; funct3 = 3'b000; func7_bit5 = 1'b0; zero = 1'b1;
    step;
    step; check_eq("beq_branch", 32'(ctl), 32'(mk(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10)));
    step; check_eq("beq_fetch", 32'(ctl), 32'(e_fetch));
    check_eq("beq_count", retired_count, 32'd5);

    // bne with zero=1: not taken
    funct3 = 3'b001;
    step;
    step; check_eq("bne_branch", 32'(ctl), 32'(mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10)));
    step; check_eq("bne_fetch", 32'(ctl), 32'(e_fetch));
    check_eq("bne_count", retired_count, 32'd6);

    // jal
    opcode = 7'b1101111; funct3 = 3'b000; zero = 1'b0;
    step; check_eq("jal_decode", 32'(ctl), 32'(mk(0,0,0,0,0,2'b11,2'b01,2'b01,3'b000,2'b00)));
    step; check_eq("jal_jal", 32'(ctl), 32'(mk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b10)));
    step; check_eq("jal_aluwb", 32'(ctl), 32'(e_alu_wb));
    step; check_eq("jal_count", retired_count, 32'd7);

    // unsupported opcode
    opcode = 7'b1110011;
    step; check_eq("ill_decode", 32'(ctl), 32'(e_dec_b));
    for (int i = 0; i < 10; i++) begin
      step;
      check_eq("ill_ctl", 32'(ctl), 32'h0);
      check_eq("ill_flag", 32'(illegal_instr), 32'h1);
    end
    check_eq("ill_count", retired_count, 32'd7);
    reset = 1'b0;
    step;
    check_eq("ill_rst_flag", 32'(illegal_instr), 32'h0);
    check_eq("ill_rst_count", retired_count, 32'h0);
    check_eq("ill_rst_ctl", 32'(ctl), 32'h0);

    // reset asserted during FETCH suppresses its strobes
    reset = 1'b1;
    step; check_eq("abort_pre", 32'(ctl), 32'(e_fetch));
    reset = 1'b0; #1;
    check_eq("abort_gated", 32'(ctl), 32'(mk(0,0,0,0,0,2'b00,2'b00,2'b10,3'b000,2'b00)));
    step; check_eq("abort_reset", 32'(ctl), 32'h0);

    // R-type with unsupported funct3
    reset = 1'b1; opcode = 7'b0110011; funct3 = 3'b001;
    step; step; step;
    check_eq("sll_no_flag_yet", 32'(illegal_instr), 32'h0);
    step;
    check_eq("sll_illegal", 32'(illegal_instr), 32'h1);
    check_eq("sll_ctl", 32'(ctl), 32'h0);

`ifdef CTRL_MEM_WAIT_EN
    // FETCH stalls for 3 cycles
    reset = 1'b0; step;
    reset = 1'b1; mem_ready = 1'b0; opcode = 7'b0000011; funct3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      step;
      check_eq("wait_fetch", 32'(ctl), 32'(mk(0,0,0,0,0,2'b00,2'b00,2'b10,3'b000,2'b00)));
    end
    mem_ready = 1'b1; #1;
    check_eq("wait_fetch_go", 32'(ctl), 32'(e_fetch));
    step; check_eq("wait_decode", 32'(ctl), 32'(e_dec_b));

    // FETCH never completes
    reset = 1'b0; step;
    reset = 1'b1; mem_ready = 1'b0;
    step;
    repeat (14) step;
    check_eq("tmo_not_yet", 32'(illegal_instr), 32'h0);
    step;
    check_eq("tmo_illegal", 32'(illegal_instr), 32'h1);
    check_eq("tmo_ctl", 32'(ctl), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
